tft_spi_monitor: RTL and testbench

//  Receive-side decoder for the 4-wire TFT SPI link driven by tft_spi: samples clk/mosi/dc/cs

---
 rtl/tft_spi_monitor_if.sv | 46 ++++
 rtl/tft_spi_monitor.sv | 253 +++++++++++++++++++++++++
 tb/tb_tft_spi_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_spi_monitor_if.sv
// ---------------------------------------------------------------------------
// tft_spi_monitor_if
//   Bundles the 4-wire TFT SPI link as seen at the analyzer tap, together with
//   the decoded byte and pixel streams that the monitor reports.
//
//   Link (driven by the master side, observed by the monitor):
//     spi_clk    link clock, data valid on its rising edge
//     spi_mosi   link data, MSB first
//     spi_dc     0 = command byte, 1 = data byte
//     spi_cs     active-low chip select
//   Decoded outputs (driven by the monitor):
//     byte_valid / byte_data / byte_dc   one pulse per received byte
//     pix_valid / pix_x / pix_y / pix_color   one pulse per RAMWR pixel
//     cmd_count                          running count of command bytes
//
//   Modports: master = link driver / consumer of results, slave = monitor.
// ---------------------------------------------------------------------------
interface tft_spi_monitor_if #(
  parameter int COORD_W = 9
);
  logic               spi_clk;
  logic               spi_mosi;
  logic               spi_dc;
  logic               spi_cs;

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_dc;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_color;
  logic [15:0]        cmd_count;

  modport master (
    output spi_clk, spi_mosi, spi_dc, spi_cs,
    input  byte_valid, byte_data, byte_dc,
    input  pix_valid, pix_x, pix_y, pix_color, cmd_count
  );

  modport slave (
    input  spi_clk, spi_mosi, spi_dc, spi_cs,
    output byte_valid, byte_data, byte_dc,
    output pix_valid, pix_x, pix_y, pix_color, cmd_count
  );
endinterface

// File: rtl/tft_spi_monitor.sv
// ---------------------------------------------------------------------------
// tft_spi_monitor
//   Receive-side decoder for the 4-wire TFT SPI link. Oversamples the link
//   with the system clock, rebuilds bytes, and follows the ILI9341-style
//   command stream (CASET / PASET / RAMWR) to report each written pixel with
//   its column, page and RGB565 colour.
//
//   Ports:
//     clk   system clock; spi_clk must stay high >=2 and low >=2 clk periods
//     rst   synchronous, active-low reset
//     bus   tft_spi_monitor_if.slave (link inputs, decoded byte/pixel outputs)
//
//   Parameters:
//     COORD_W  width of coordinates and window registers (16-bit params are
//              truncated to this width)
//     X_MAX    column-end value after reset
//     Y_MAX    page-end value after reset
// ---------------------------------------------------------------------------
module tft_spi_monitor #(
  parameter int COORD_W = 9,
  parameter int X_MAX   = 239,
  parameter int Y_MAX   = 319
) (
  input  logic             clk,
  input  logic             rst,
  tft_spi_monitor_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CASET    = 3'd1;
  localparam logic [2:0] ST_PASET    = 3'd2;
  localparam logic [2:0] ST_RAMWR_HI = 3'd3;
  localparam logic [2:0] ST_RAMWR_LO = 3'd4;
  localparam logic [2:0] ST_SKIP     = 3'd5;

  localparam logic [COORD_W-1:0] XE_RST    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YE_RST    = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  // Synchroniser stages, bit order {cs, dc, mosi, clk}.
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic               clk_prev_q, clk_prev_d;

  // One registered stage after the synchroniser: rise strobe plus the
  // mosi/dc/cs levels taken from the same synced sample.
  logic               rise_q, rise_d;
  logic               mosi_q, mosi_d;
  logic               dc_q, dc_d;
  logic               cs_q, cs_d;

  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         shift_q, shift_d;
  logic               byte_valid_q, byte_valid_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               byte_dc_q, byte_dc_d;

  logic [2:0]         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [23:0]        shadow_q, shadow_d;
  logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d;
  logic [COORD_W-1:0] ys_q, ys_d, ye_q, ye_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]         hi_q, hi_d;
  logic               pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]        pix_color_q, pix_color_d;
  logic [15:0]        cmd_count_q, cmd_count_d;

  logic [31:0]        param_word;

  // Front end and byte assembly. A raw spi_clk rise seen at edge N reaches
  // sync2 at N+1, becomes rise_q at N+2 and shifts the bit at N+3.
  // NOTE: every _d signal gets its hold value first, so no branch can leave
  // it unassigned and infer a latch.
  always_comb begin
    sync1_d      = {bus.spi_cs, bus.spi_dc, bus.spi_mosi, bus.spi_clk};
    sync2_d      = sync1_q;
    clk_prev_d   = sync2_q[0];
    rise_d       = sync2_q[0] & ~clk_prev_q;
    mosi_d       = sync2_q[1];
    dc_d         = sync2_q[2];
    cs_d         = sync2_q[3];

    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;

    if (cs_q) begin
      // Deselect throws away any partial byte; decoder state is untouched.
      bit_cnt_d = 3'd0;
    end else if (rise_q) begin
      shift_d = {shift_q[5:0], mosi_q};
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, mosi_q};
        byte_dc_d    = dc_q;
      end
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Command stream decoder, advanced once per received byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    cmd_count_d = cmd_count_q;
    param_word  = {shadow_q, byte_data_q};

    if (byte_valid_q) begin
      if (!byte_dc_q) begin
        // A command always restarts decoding, whatever was in progress.
        cmd_count_d = cmd_count_q + 16'd1;
        idx_d       = 2'd0;
        case (byte_data_q)
          8'h2A:   state_d = ST_CASET;
          8'h2B:   state_d = ST_PASET;
          8'h2C: begin
            state_d = ST_RAMWR_HI;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            shadow_d = param_word[23:0];
            idx_d    = idx_q + 2'd1;
            // Window is only committed once all four bytes are in, so an
            // interrupted sequence leaves the old window in place.
            if (idx_q == 2'd3) begin
              if (state_q == ST_CASET) begin
                xs_d = COORD_W'(param_word[31:16]);
                xe_d = COORD_W'(param_word[15:0]);
              end else begin
                ys_d = COORD_W'(param_word[31:16]);
                ye_d = COORD_W'(param_word[15:0]);
              end
              state_d = ST_IDLE;
            end
          end
          ST_RAMWR_HI: begin
            hi_d    = byte_data_q;
            state_d = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_color_d = {hi_q, byte_data_q};
            // Equality test (not >=) lets xs>xe wrap through 2^COORD_W.
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : y_q + COORD_ONE;
            end else begin
              x_d = x_q + COORD_ONE;
            end
            state_d = ST_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments so every flop updates from the values
  // present before the edge; there is no memory array, so every register,
  // synchronisers included, takes its reset value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      clk_prev_q   <= 1'b0;
      rise_q       <= 1'b0;
      mosi_q       <= 1'b0;
      dc_q         <= 1'b0;
      cs_q         <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      shadow_q     <= '0;
      xs_q         <= '0;
      xe_q         <= XE_RST;
      ys_q         <= '0;
      ye_q         <= YE_RST;
      x_q          <= '0;
      y_q          <= '0;
      hi_q         <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
      cmd_count_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      clk_prev_q   <= clk_prev_d;
      rise_q       <= rise_d;
      mosi_q       <= mosi_d;
      dc_q         <= dc_d;
      cs_q         <= cs_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hi_q         <= hi_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      cmd_count_q  <= cmd_count_d;
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_dc    = byte_dc_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_color  = pix_color_q;
  assign bus.cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_tft_spi_monitor.sv
// ---------------------------------------------------------------------------
// tb_tft_spi_monitor
//   Drives the TFT SPI link at clk/4 and compares the monitor's byte and
//   pixel streams against a segment-level reference model of the command
//   protocol, plus hand-derived vectors for the documented corner cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tft_spi_monitor;

  localparam int COORD_W = 9;
  localparam int X_MAX   = 239;
  localparam int Y_MAX   = 319;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } byte_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] color;
  } pix_t;

  typedef struct {
    logic [15:0] color;
    logic [8:0]  exp_x;
    logic [8:0]  exp_y;
  } pix_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tft_spi_monitor_if #(.COORD_W(COORD_W)) bus ();

  tft_spi_monitor #(
    .COORD_W(COORD_W),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  byte_t sent[$];       // bytes the link actually carried since last reset
  byte_t got_bytes[$];  // byte_valid samples
  pix_t  got_pix[$];    // pix_valid samples
  pix_t  exp_pix[$];    // reference model output

  always @(negedge clk) begin
    if (bus.byte_valid) got_bytes.push_back('{data: bus.byte_data, dc: bus.byte_dc});
    if (bus.pix_valid)  got_pix.push_back('{x: bus.pix_x, y: bus.pix_y, color: bus.pix_color});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bus.spi_clk  = 1'b0;
      bus.spi_mosi = b[i];
      bus.spi_dc   = dc;
      @(negedge clk);
      @(negedge clk);
      bus.spi_clk = 1'b1;
      @(negedge clk);
    end
    sent.push_back('{data: b, dc: dc});
  endtask

  task automatic settle();
    @(negedge clk);
    bus.spi_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.spi_clk = 1'b0;
    bus.spi_cs  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got_bytes.delete();
    got_pix.delete();
    sent.delete();
  endtask

  // Reference: split the byte stream into command segments (command plus
  // the data bytes that follow it) and interpret each segment as a whole.
  task automatic model_pixels();
    int xs = 0, xe = X_MAX, ys = 0, ye = Y_MAX;
    int x, y;
    int i = 0;
    int m = 1 << COORD_W;
    logic [7:0] cmd;
    logic [7:0] params[$];
    exp_pix.delete();
    while (i < sent.size()) begin
      if (sent[i].dc) begin
        i++;
        continue;
      end
      cmd = sent[i].data;
      i++;
      params.delete();
      while (i < sent.size() && sent[i].dc) begin
        params.push_back(sent[i].data);
        i++;
      end
      if (cmd == 8'h2A && params.size() >= 4) begin
        xs = int'({params[0], params[1]}) % m;
        xe = int'({params[2], params[3]}) % m;
      end else if (cmd == 8'h2B && params.size() >= 4) begin
        ys = int'({params[0], params[1]}) % m;
        ye = int'({params[2], params[3]}) % m;
      end else if (cmd == 8'h2C) begin
        x = xs;
        y = ys;
        for (int k = 0; k + 1 < params.size(); k += 2) begin
          exp_pix.push_back('{x: 9'(x), y: 9'(y), color: {params[k], params[k+1]}});
          if (x == xe) begin
            x = xs;
            y = (y == ye) ? ys : (y + 1) % m;
          end else begin
            x = (x + 1) % m;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    int bad = 0;
    int ncmd = 0;
    model_pixels();
    check({name, " byte count"}, got_bytes.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got_bytes.size(); i++)
      if (got_bytes[i] !== sent[i]) bad++;
    check({name, " byte errors"}, bad, 0);
    check({name, " pix count"}, got_pix.size(), exp_pix.size());
    bad = 0;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      if (got_pix[i] !== exp_pix[i]) bad++;
    check({name, " pix errors"}, bad, 0);
    foreach (sent[i]) if (!sent[i].dc) ncmd++;
    check({name, " cmd_count"}, bus.cmd_count, ncmd % 65536);
  endtask

  task automatic random_round(input int r);
    logic [7:0] c;
    int pick, n;
    do_reset();
    if ($urandom_range(1, 0) == 1) spi_byte(8'($urandom_range(255, 0)), 1'b1);
    for (int s = 0; s < 6; s++) begin
      pick = $urandom_range(3, 0);
      if (pick == 0)      c = 8'h2A;
      else if (pick == 1) c = 8'h2B;
      else if (pick == 2) c = 8'h2C;
      else begin
        do c = 8'($urandom_range(255, 0)); while (c == 8'h2A || c == 8'h2B || c == 8'h2C);
      end
      n = (c == 8'h2C) ? $urandom_range(8, 0) : $urandom_range(6, 0);
      spi_byte(c, 1'b0);
      for (int k = 0; k < n; k++) spi_byte(8'($urandom_range(255, 0)), 1'b1);
    end
    settle();
    check_model($sformatf("random%0d", r));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_vec_t vec[5];
    vec[0] = '{16'hF800, 9'd10, 9'd20};
    vec[1] = '{16'h07E0, 9'd11, 9'd20};
    vec[2] = '{16'h001F, 9'd10, 9'd21};
    vec[3] = '{16'hFFFF, 9'd11, 9'd21};
    vec[4] = '{16'h1234, 9'd10, 9'd20};

    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_dc   = 1'b0;
    bus.spi_cs   = 1'b0;

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("reset byte_valid", bus.byte_valid, 0);
    check("reset pix_valid",  bus.pix_valid, 0);
    check("reset outputs", {bus.byte_data, bus.byte_dc, bus.pix_x, bus.pix_y}, 0);
    check("reset color/count", {bus.pix_color, bus.cmd_count}, 0);
    do_reset();

    // Single command byte.
    spi_byte(8'h2A, 1'b0);
    settle();
    check("t1 byte pulses", got_bytes.size(), 1);
    if (got_bytes.size() > 0) begin
      check("t1 byte_data", got_bytes[0].data, 8'h2A);
      check("t1 byte_dc", got_bytes[0].dc, 0);
    end
    check("t1 cmd_count", bus.cmd_count, 1);

    // Windowed RAMWR, table-driven pixels.
    do_reset();
    spi_byte(8'h2A, 1'b0);
    spi_byte(8'h00, 1'b1); spi_byte(8'h0A, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h0B, 1'b1);
    spi_byte(8'h2B, 1'b0);
    spi_byte(8'h00, 1'b1); spi_byte(8'h14, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h15, 1'b1);
    spi_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      spi_byte(vec[i].color[15:8], 1'b1);
      spi_byte(vec[i].color[7:0], 1'b1);
      settle();
      check($sformatf("t2 px%0d count", i), got_pix.size(), i + 1);
      if (got_pix.size() > i) begin
        check($sformatf("t2 px%0d x", i), got_pix[i].x, vec[i].exp_x);
        check($sformatf("t2 px%0d y", i), got_pix[i].y, vec[i].exp_y);
        check($sformatf("t2 px%0d color", i), got_pix[i].color, vec[i].color);
      end
    end
    check("t2 pix_x hold", bus.pix_x, 10);
    check_model("t2");

    // Interrupted CASET leaves the window alone.
    do_reset();
    spi_byte(8'h2A, 1'b0);
    spi_byte(8'h00, 1'b1); spi_byte(8'h05, 1'b1);
    spi_byte(8'h2C, 1'b0);
    spi_byte(8'hBE, 1'b1); spi_byte(8'hEF, 1'b1);
    settle();
    check("t3 pix count", got_pix.size(), 1);
    if (got_pix.size() > 0) check("t3 pix xy", {got_pix[0].x, got_pix[0].y}, 0);
    check_model("t3");

    // Chip-select abort mid-byte.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.spi_clk = 1'b0; bus.spi_mosi = i[0];
      @(negedge clk); @(negedge clk); bus.spi_clk = 1'b1; @(negedge clk);
    end
    @(negedge clk); bus.spi_clk = 1'b0; bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h36, 1'b0);
    settle();
    check("t4 byte pulses", got_bytes.size(), 1);
    if (got_bytes.size() > 0) check("t4 byte_data", got_bytes[0].data, 8'h36);
    check("t4 cmd_count", bus.cmd_count, 1);

    // Reset in the middle of a pixel.
    do_reset();
    spi_byte(8'h2C, 1'b0);
    spi_byte(8'h12, 1'b1);
    settle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("t6 reset cmd_count", bus.cmd_count, 0);
    check("t6 reset byte_data", bus.byte_data, 0);
    rst = 1'b1;
    @(negedge clk);
    got_bytes.delete(); got_pix.delete(); sent.delete();
    spi_byte(8'hAB, 1'b1);
    settle();
    check("t6 byte pulses", got_bytes.size(), 1);
    if (got_bytes.size() > 0) check("t6 byte", got_bytes[0], {8'hAB, 1'b1});
    check("t6 no pixel", got_pix.size(), 0);

    // Power-on page end: single column, y runs 0..319 and wraps.
    do_reset();
    spi_byte(8'h2A, 1'b0);
    for (int i = 0; i < 4; i++) spi_byte(8'h00, 1'b1);
    spi_byte(8'h2C, 1'b0);
    for (int i = 0; i < 321; i++) begin
      spi_byte(8'(i >> 8), 1'b1);
      spi_byte(8'(i), 1'b1);
    end
    settle();
    if (got_pix.size() == 321) begin
      check("t5a last-1 xy", {got_pix[319].x, got_pix[319].y}, {9'd0, 9'd319});
      check("t5a last xy", {got_pix[320].x, got_pix[320].y}, {9'd0, 9'd0});
    end
    check_model("t5a");

    // Power-on column end: single page at 319, x runs 0..239 and wraps.
    do_reset();
    spi_byte(8'h2B, 1'b0);
    spi_byte(8'h01, 1'b1); spi_byte(8'h3F, 1'b1); spi_byte(8'h01, 1'b1); spi_byte(8'h3F, 1'b1);
    spi_byte(8'h2C, 1'b0);
    for (int i = 0; i < 241; i++) begin
      spi_byte(8'h5A, 1'b1);
      spi_byte(8'(i), 1'b1);
    end
    settle();
    if (got_pix.size() == 241) begin
      check("t5b last-1 xy", {got_pix[239].x, got_pix[239].y}, {9'd239, 9'd319});
      check("t5b last xy", {got_pix[240].x, got_pix[240].y}, {9'd0, 9'd319});
    end
    check_model("t5b");

    // xs > xe: x wraps through 511 to reach xe.
    do_reset();
    spi_byte(8'h2A, 1'b0);
    spi_byte(8'h01, 1'b1); spi_byte(8'hFE, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h01, 1'b1);
    spi_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      spi_byte(8'hC0, 1'b1);
      spi_byte(8'(i), 1'b1);
    end
    settle();
    if (got_pix.size() == 5) begin
      check("wrap px2 x", got_pix[2].x, 0);
      check("wrap px4 xy", {got_pix[4].x, got_pix[4].y}, {9'd510, 9'd1});
    end
    check_model("wrap");

    for (int r = 0; r < 4; r++) random_round(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
